// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_controller
// Description : Control end of the datapath. Holds the instruction register,
//               decodes the 16-bit instruction and sequences the datapath
//               strobes for one instruction at a time (Moore FSM, registered
//               strobes).
// Ports       : clk, reset (async, active-high)
//               in[15:0], load, s       - instruction word, IR capture, start
//               w                       - 1 = idle, ready for load/s
//               readnum/writenum[2:0]   - register index for the current step
//               write, loada, loadb, loadc, loads, asel, bsel - strobes
//               vsel[3:0]               - one-hot writeback select
//               shift[1:0], ALUop[1:0]  - from IR
//               sximm8/sximm5[15:0]     - sign-extended immediates from IR
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_OP     = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    localparam logic [2:0] c_OPC_ALU   = 3'b101;
    localparam logic [2:0] c_OPC_MOV   = 3'b110;
    localparam logic [1:0] c_OP_MOVIMM = 2'b10;
    localparam logic [1:0] c_OP_MOVREG = 2'b00;
    localparam logic [1:0] c_OP_CMP    = 2'b01;
    localparam logic [1:0] c_OP_MVN    = 2'b11;
    localparam logic [3:0] c_VSEL_C    = 4'b0001;
    localparam logic [3:0] c_VSEL_IMM8 = 4'b0100;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    // Registered strobes; one register feeds both readnum and writenum.
    logic       r_w, r_write, r_loada, r_loadb, r_asel, r_loadc, r_loads;
    logic [2:0] r_nsel;
    logic [3:0] r_vsel;

    logic       w_nx_w, w_nx_write, w_nx_loada, w_nx_loadb, w_nx_asel;
    logic       w_nx_loadc, w_nx_loads;
    logic [2:0] w_nx_nsel;
    logic [3:0] w_nx_vsel;

    // IR fields
    logic [2:0] w_opcode, w_rn, w_rd, w_rm;
    logic [1:0] w_op, w_sh;
    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    logic w_is_alu, w_is_mov_imm, w_is_mov_reg, w_is_cmp, w_is_mvn;
    assign w_is_alu     = (w_opcode == c_OPC_ALU);
    assign w_is_mov_imm = (w_opcode == c_OPC_MOV) && (w_op == c_OP_MOVIMM);
    assign w_is_mov_reg = (w_opcode == c_OPC_MOV) && (w_op == c_OP_MOVREG);
    assign w_is_cmp     = w_is_alu && (w_op == c_OP_CMP);
    assign w_is_mvn     = w_is_alu && (w_op == c_OP_MVN);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:   if (s) w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_is_mov_imm)
                    w_next_state = S_WR_IMM;
                else if (w_is_mov_reg || w_is_mvn)
                    w_next_state = S_GET_B;     // single-operand: skip A
                else if (w_is_alu)
                    w_next_state = S_GET_A;     // ADD, CMP, AND
                else
                    w_next_state = S_WAIT;      // undefined: no strobes
            end
            S_GET_A:  w_next_state = S_GET_B;
            S_GET_B:  w_next_state = S_OP;
            S_OP:     w_next_state = w_is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: w_next_state = S_WAIT;
            S_WR_IMM: w_next_state = S_WAIT;
            default:  w_next_state = S_WAIT;
        endcase
    end

    // Strobes for the state about to be entered. IR cannot change on the
    // same edge except when entering DECODE, which carries no strobes, so
    // decoding the current IR here is safe.
    always_comb begin
        w_nx_w     = 1'b0;
        w_nx_write = 1'b0;
        w_nx_loada = 1'b0;
        w_nx_loadb = 1'b0;
        w_nx_asel  = 1'b0;
        w_nx_loadc = 1'b0;
        w_nx_loads = 1'b0;
        w_nx_nsel  = 3'd0;
        w_nx_vsel  = c_VSEL_C;
        case (w_next_state)
            S_WAIT:  w_nx_w = 1'b1;
            S_GET_A: begin
                w_nx_nsel  = w_rn;
                w_nx_loada = 1'b1;
            end
            S_GET_B: begin
                w_nx_nsel  = w_rm;
                w_nx_loadb = 1'b1;
            end
            S_OP: begin
                w_nx_asel = w_is_mov_reg || w_is_mvn;
                if (w_is_cmp) w_nx_loads = 1'b1;
                else          w_nx_loadc = 1'b1;
            end
            S_WR_REG: begin
                w_nx_nsel  = w_rd;
                w_nx_write = 1'b1;
                w_nx_vsel  = c_VSEL_C;
            end
            S_WR_IMM: begin
                w_nx_nsel  = w_rn;
                w_nx_write = 1'b1;
                w_nx_vsel  = c_VSEL_IMM8;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
            r_w     <= 1'b1;
            r_write <= 1'b0;
            r_loada <= 1'b0;
            r_loadb <= 1'b0;
            r_asel  <= 1'b0;
            r_loadc <= 1'b0;
            r_loads <= 1'b0;
            r_nsel  <= 3'd0;
            r_vsel  <= c_VSEL_C;
        end else begin
            r_state <= w_next_state;
            // IR is frozen while an instruction is in flight.
            if (load && (r_state == S_WAIT))
                r_ir <= in;
            r_w     <= w_nx_w;
            r_write <= w_nx_write;
            r_loada <= w_nx_loada;
            r_loadb <= w_nx_loadb;
            r_asel  <= w_nx_asel;
            r_loadc <= w_nx_loadc;
            r_loads <= w_nx_loads;
            r_nsel  <= w_nx_nsel;
            r_vsel  <= w_nx_vsel;
        end
    end

    assign w        = r_w;
    assign readnum  = r_nsel;
    assign writenum = r_nsel;
    assign write    = r_write;
    assign vsel     = r_vsel;
    assign loada    = r_loada;
    assign loadb    = r_loadb;
    assign asel     = r_asel;
    assign bsel     = 1'b0;     // sximm5 path is never selected by this ISA
    assign loadc    = r_loadc;
    assign loads    = r_loads;
    assign shift    = w_sh;
    assign ALUop    = w_is_alu ? w_op : 2'b00;
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_controller
// Description : Self-checking bench for cpu_controller. Table of hand-decoded
//               instructions, hand-written reset/busy sequences, and random
//               instructions checked cycle by cycle against a step-list model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset, load, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8, sximm5;

    cpu_controller dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .loadc(loadc), .loads(loads), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] rnum;
        logic [2:0] wnum;
        logic       wr;
        logic [3:0] vsel;
        logic       la, lb, asl, bsl, lc, ls;
        logic [1:0] sh;
        logic [1:0] alu;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        int          lat;
        logic [15:0] x8;
        logic [15:0] x5;
        logic [1:0]  sh;
        logic [1:0]  alu;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    vec_t vecs[9];

    function automatic obs_t get_obs();
        obs_t o;
        o.w = w; o.rnum = readnum; o.wnum = writenum; o.wr = write;
        o.vsel = vsel; o.la = loada; o.lb = loadb; o.asl = asel;
        o.bsl = bsel; o.lc = loadc; o.ls = loads; o.sh = shift; o.alu = ALUop;
        return o;
    endfunction

    // Nothing asserted; shift and ALUop still follow IR.
    function automatic obs_t base_obs(input logic [15:0] ir);
        obs_t o;
        o      = '0;
        o.vsel = 4'b0001;
        o.sh   = ir[4:3];
        o.alu  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        return o;
    endfunction

    function automatic obs_t idle_of(input logic [15:0] ir);
        obs_t o;
        o   = base_obs(ir);
        o.w = 1'b1;
        return o;
    endfunction

    // Expected busy cycles (one entry per edge after s) for instruction ir.
    function automatic void build_model(input logic [15:0] ir);
        obs_t o;
        logic [2:0] rn, rd, rm;
        bit mov_imm, mov_reg, add, cmp, is_and, mvn;
        rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
        mov_imm = (ir[15:11] == 5'b11010);
        mov_reg = (ir[15:11] == 5'b11000);
        add     = (ir[15:11] == 5'b10100);
        cmp     = (ir[15:11] == 5'b10101);
        is_and  = (ir[15:11] == 5'b10110);
        mvn     = (ir[15:11] == 5'b10111);
        exp_q.delete();
        exp_q.push_back(base_obs(ir));             // decode cycle
        if (mov_imm) begin
            o = base_obs(ir); o.rnum = rn; o.wnum = rn; o.wr = 1'b1;
            o.vsel = 4'b0100;
            exp_q.push_back(o);
        end else if (mov_reg || mvn || add || cmp || is_and) begin
            if (add || cmp || is_and) begin
                o = base_obs(ir); o.rnum = rn; o.wnum = rn; o.la = 1'b1;
                exp_q.push_back(o);
            end
            o = base_obs(ir); o.rnum = rm; o.wnum = rm; o.lb = 1'b1;
            exp_q.push_back(o);
            o = base_obs(ir); o.asl = mov_reg || mvn;
            if (cmp) o.ls = 1'b1; else o.lc = 1'b1;
            exp_q.push_back(o);
            if (!cmp) begin
                o = base_obs(ir); o.rnum = rd; o.wnum = rd; o.wr = 1'b1;
                exp_q.push_back(o);
            end
        end
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Start ir from WAIT (called at a negedge). disturb: 0 none, 1 random
    // load/s/in while busy, 2 load+s with in=D0FF every busy cycle.
    task automatic run_instr(input logic [15:0] ir, input bit do_load,
                             input int disturb, input int lat_exp);
        int   lat;
        obs_t e;
        build_model(ir);
        in = ir; load = do_load; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            e = (k <= exp_q.size()) ? exp_q[k-1] : idle_of(ir);
            check_obs($sformatf("step%0d_ir%h", k, ir), get_obs(), e);
            load = 1'b0; s = 1'b0;
            if (w === 1'b1) begin
                lat = k;
                break;
            end
            if (disturb == 1) begin
                in = 16'($urandom); load = 1'($urandom); s = 1'($urandom);
            end else if (disturb == 2) begin
                in = 16'hD0FF; load = 1'b1; s = 1'b1;
            end
            @(negedge clk);
        end
        load = 1'b0; s = 1'b0;
        checks++;
        if (lat != lat_exp) begin
            errors++;
            $display("FAIL latency_ir%h got=%0d exp=%0d", ir, lat, lat_exp);
        end
        check16($sformatf("sximm8_ir%h", ir), sximm8, {{8{ir[7]}}, ir[7:0]});
        check16($sformatf("sximm5_ir%h", ir), sximm5, {{11{ir[4]}}, ir[4:0]});
    endtask

    initial begin
        logic [15:0] rir;
        int          lat;

        vecs[0] = '{16'hD0FD, 3, 16'hFFFD, 16'hFFFD, 2'b11, 2'b00}; // MOV R0,#-3
        vecs[1] = '{16'hA148, 6, 16'h0048, 16'h0008, 2'b01, 2'b00}; // ADD R2,R1,R0,LSL#1
        vecs[2] = '{16'hA900, 5, 16'h0000, 16'h0000, 2'b00, 2'b01}; // CMP R1,R0
        vecs[3] = '{16'hB8E1, 5, 16'hFFE1, 16'h0001, 2'b00, 2'b11}; // MVN R7,R1
        vecs[4] = '{16'hC0A3, 5, 16'hFFA3, 16'h0003, 2'b00, 2'b00}; // MOV R5,R3
        vecs[5] = '{16'hB25F, 6, 16'h005F, 16'hFFFF, 2'b11, 2'b10}; // AND R2,R2,R7,ASR
        vecs[6] = '{16'hE000, 2, 16'h0000, 16'h0000, 2'b00, 2'b00}; // undefined opcode
        vecs[7] = '{16'hC800, 2, 16'h0000, 16'h0000, 2'b00, 2'b00}; // undefined 110/01
        vecs[8] = '{16'hD57F, 3, 16'h007F, 16'hFFFF, 2'b11, 2'b00}; // MOV R5,#127

        reset = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0000;

        // Reset asserted between edges must act at once.
        #3 reset = 1'b1;
        #1 check_obs("async_reset", get_obs(), idle_of(16'h0000));
        check16("reset_ir", sximm8, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_obs($sformatf("idle%0d", i), get_obs(), idle_of(16'h0000));
        end

        // Table of instructions.
        for (int i = 0; i < 9; i++) begin
            run_instr(vecs[i].instr, 1'b1, 0, vecs[i].lat);
            check16($sformatf("tab_x8_%0d", i), sximm8, vecs[i].x8);
            check16($sformatf("tab_x5_%0d", i), sximm5, vecs[i].x5);
            check16($sformatf("tab_sh_%0d", i), {14'd0, shift}, {14'd0, vecs[i].sh});
            check16($sformatf("tab_alu_%0d", i), {14'd0, ALUop}, {14'd0, vecs[i].alu});
        end

        // Busy protection: load/s pulsed with a MOV imm while ADD runs.
        run_instr(16'hA148, 1'b1, 2, 6);
        check_obs("busy_after", get_obs(), idle_of(16'hA148));

        // Load without start, then start without load.
        in = 16'hD57F; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_obs("load_only", get_obs(), idle_of(16'hD57F));
        run_instr(16'hD57F, 1'b0, 0, 3);

        // Reset during GET_B of MVN.
        build_model(16'hB8E1);
        in = 16'hB8E1; load = 1'b1; s = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b0;
        @(negedge clk);
        check_obs("mvn_getb", get_obs(), exp_q[1]);
        #2 reset = 1'b1;
        #1 check_obs("mid_reset", get_obs(), idle_of(16'h0000));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_obs($sformatf("post_reset%0d", i), get_obs(), idle_of(16'h0000));
        end
        run_instr(16'h0000, 1'b0, 0, 2);

        // Random instructions with random busy-time disturbance.
        for (int i = 0; i < 40; i++) begin
            rir = 16'($urandom);
            case ($urandom_range(0, 3))
                1: rir[15:13] = 3'b101;
                2: rir[15:13] = 3'b110;
                3: rir[15:11] = 5'b11010;
                default: ;
            endcase
            build_model(rir);
            lat = exp_q.size() + 1;
            run_instr(rir, 1'b1, 1, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
